// File: rtl/route_reserve_allocator_if.sv
// route_reserve_allocator_if
// Groups the request/relieve/status/crossbar-select signals exchanged between the
// input-port control logics (master side) and the switch allocator (slave side).
//
// Handshake: an input raises routeReserveRequestValid[i] with its destination in
// slice i of routeReserveRequest and holds both until routeReserveStatus[i] rises.
// Status is the grant: it stays high for the life of the reservation. The input
// then pulses routeRelieve[i] for one cycle to hand the output back. No separate
// ready exists; status is the only acknowledgement.
//
// Signals:
//   routeReserveRequestValid  N          bit i: input i wants an output
//   routeReserveRequest       N*RW       slice i: requested output index
//   routeRelieve              N          bit i: input i releases its output
//   routeReserveStatus        N          bit i: input i holds its output
//   outSelect                 N*RW       slice o: input driving output o
//   outBusy                   N          bit o: output o reserved
//   badRequest                1          sticky out-of-range request flag
interface route_reserve_allocator_if #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
);
    logic [N-1:0]               routeReserveRequestValid;
    logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
    logic [N-1:0]               routeRelieve;
    logic [N-1:0]               routeReserveStatus;
    logic [N*REQUEST_WIDTH-1:0] outSelect;
    logic [N-1:0]               outBusy;
    logic                       badRequest;

    modport master (
        output routeReserveRequestValid, routeReserveRequest, routeRelieve,
        input  routeReserveStatus, outSelect, outBusy, badRequest
    );

    modport slave (
        input  routeReserveRequestValid, routeReserveRequest, routeRelieve,
        output routeReserveStatus, outSelect, outBusy, badRequest
    );
endinterface

// File: rtl/route_reserve_allocator.sv
// route_reserve_allocator
// Switch allocator for one mesh router. Each output port runs a FREE/RESERVED
// state machine with its own round-robin pointer; an output is handed to the
// first eligible requester at or after its pointer and held until the owning
// input pulses routeRelieve. The stored owner doubles as the crossbar select.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-low reset
//   bus   slave modport of route_reserve_allocator_if (requests in, grants out)
module route_reserve_allocator #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    route_reserve_allocator_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        FREE     = 1'b0,
        RESERVED = 1'b1
    } outState_t;

    outState_t stateQ [N];
    outState_t stateD [N];

    logic [N-1:0][REQUEST_WIDTH-1:0] selQ, selD;
    logic [N-1:0][REQUEST_WIDTH-1:0] ptrQ, ptrD;
    logic [N-1:0][REQUEST_WIDTH-1:0] holdDestQ, holdDestD;
    logic [N-1:0][REQUEST_WIDTH-1:0] req;
    logic [N-1:0]                    statusQ, statusD;
    logic                            badQ, badD;

    int               idxInt;
    logic [IDX_W-1:0] idx;
    logic             found;

    assign req = bus.routeReserveRequest;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < N; o++) begin
                stateQ[o] <= FREE;
            end
            selQ      <= '0;
            ptrQ      <= '0;
            holdDestQ <= '0;
            statusQ   <= '0;
            badQ      <= 1'b0;
        end else begin
            for (int o = 0; o < N; o++) begin
                stateQ[o] <= stateD[o];
            end
            selQ      <= selD;
            ptrQ      <= ptrD;
            holdDestQ <= holdDestD;
            statusQ   <= statusD;
            badQ      <= badD;
        end
    end

    // Next-state: relieve, then arbitration of outputs that are FREE this cycle
    always_comb begin
        for (int o = 0; o < N; o++) begin
            stateD[o] = stateQ[o];
        end
        selD      = selQ;
        ptrD      = ptrQ;
        holdDestD = holdDestQ;
        statusD   = statusQ;
        badD      = badQ;
        idxInt    = 0;
        idx       = '0;
        found     = 1'b0;

        for (int i = 0; i < N; i++) begin
            if (bus.routeReserveRequestValid[i] && (int'(req[i]) >= N)) begin
                badD = 1'b1;
            end
        end

        // Relieve from a non-holder is dropped by the statusQ qualifier.
        for (int i = 0; i < N; i++) begin
            if (bus.routeRelieve[i] && statusQ[i]) begin
                statusD[i] = 1'b0;
                for (int o = 0; o < N; o++) begin
                    if (holdDestQ[i] == REQUEST_WIDTH'(o)) begin
                        stateD[o] = FREE;
                    end
                end
            end
        end

        // Arbitration looks at stateQ, so an output freed this cycle is only
        // re-granted next cycle. Out-of-range indices never match any o.
        for (int o = 0; o < N; o++) begin
            found = 1'b0;
            if (stateQ[o] == FREE) begin
                for (int k = 0; k < N; k++) begin
                    idxInt = (int'(ptrQ[o]) + k) % N;
                    idx    = IDX_W'(idxInt);
                    if (!found && bus.routeReserveRequestValid[idx] &&
                        (req[idx] == REQUEST_WIDTH'(o)) && !statusQ[idx]) begin
                        found          = 1'b1;
                        stateD[o]      = RESERVED;
                        selD[o]        = REQUEST_WIDTH'(idxInt);
                        ptrD[o]        = REQUEST_WIDTH'((idxInt + 1) % N);
                        statusD[idx]   = 1'b1;
                        holdDestD[idx] = REQUEST_WIDTH'(o);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.outBusy = '0;
        for (int o = 0; o < N; o++) begin
            bus.outBusy[o] = (stateQ[o] == RESERVED);
        end
    end

    assign bus.routeReserveStatus = statusQ;
    assign bus.outSelect          = selQ;
    assign bus.badRequest         = badQ;
endmodule

// File: tb/tb_route_reserve_allocator.sv
module tb_route_reserve_allocator;
    localparam int N  = 4;
    localparam int RW = 3;
    localparam int W  = 4 + 4 + 12 + 1;

    logic clk;
    logic rst;

    route_reserve_allocator_if #(.N(N), .REQUEST_WIDTH(RW)) bus ();

    route_reserve_allocator #(.N(N), .REQUEST_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] req;
        logic [3:0]  relieve;
        logic [3:0]  status;
        logic [3:0]  busy;
        logic [11:0] sel;
        logic        bad;
        string       name;
    } vec_t;

    vec_t           vecs [19];
    logic [W-1:0]   exp_q [$];
    int             check_cnt = 0;
    int             pass_cnt  = 0;

    function automatic logic [11:0] r(input int a3, input int a2, input int a1, input int a0);
        r = {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // driver + scoreboard: expectation queued at drive, popped after the edge
    task automatic step(input logic [3:0] v, input logic [11:0] rq, input logic [3:0] rl,
                        input logic [3:0] es, input logic [3:0] eb, input logic [11:0] esel,
                        input logic ebad, input string name);
        logic [W-1:0] e;
        @(negedge clk);
        bus.routeReserveRequestValid = v;
        bus.routeReserveRequest      = rq;
        bus.routeRelieve             = rl;
        exp_q.push_back({es, eb, esel, ebad});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, " queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({name, " status"}, 32'(bus.routeReserveStatus), 32'(e[20:17]));
            check({name, " busy"},   32'(bus.outBusy),            32'(e[16:13]));
            check({name, " sel"},    32'(bus.outSelect),          32'(e[12:1]));
            check({name, " bad"},    32'(bus.badRequest),         32'(e[0]));
        end
    endtask

    task automatic idle_inputs();
        bus.routeReserveRequestValid = '0;
        bus.routeReserveRequest      = '0;
        bus.routeRelieve             = '0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " status"}, 32'(bus.routeReserveStatus), 32'd0);
        check({name, " busy"},   32'(bus.outBusy),            32'd0);
        check({name, " sel"},    32'(bus.outSelect),          32'd0);
        check({name, " bad"},    32'(bus.badRequest),         32'd0);
    endtask

    initial begin
        //           valid    req           relieve  status   busy     sel           bad
        vecs[0]  = '{4'b0000, r(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, r(0,0,0,0), 1'b0, "idle"};
        vecs[1]  = '{4'b0001, r(0,0,0,3), 4'b0000, 4'b0001, 4'b1000, r(0,0,0,0), 1'b0, "in0_to_out3"};
        vecs[2]  = '{4'b0000, r(0,0,0,0), 4'b0001, 4'b0000, 4'b0000, r(0,0,0,0), 1'b0, "relieve0"};
        vecs[3]  = '{4'b0111, r(0,1,1,1), 4'b0000, 4'b0001, 4'b0010, r(0,0,0,0), 1'b0, "rr_grant0"};
        vecs[4]  = '{4'b0110, r(0,1,1,1), 4'b0000, 4'b0001, 4'b0010, r(0,0,0,0), 1'b0, "rr_hold"};
        vecs[5]  = '{4'b0110, r(0,1,1,1), 4'b0001, 4'b0000, 4'b0000, r(0,0,0,0), 1'b0, "rr_rel0_nohandover"};
        vecs[6]  = '{4'b0110, r(0,1,1,1), 4'b0000, 4'b0010, 4'b0010, r(0,0,1,0), 1'b0, "rr_grant1"};
        vecs[7]  = '{4'b0100, r(0,1,1,1), 4'b0010, 4'b0000, 4'b0000, r(0,0,1,0), 1'b0, "rr_rel1"};
        vecs[8]  = '{4'b0100, r(0,1,1,1), 4'b0000, 4'b0100, 4'b0010, r(0,0,2,0), 1'b0, "rr_grant2"};
        vecs[9]  = '{4'b0000, r(0,0,0,0), 4'b0100, 4'b0000, 4'b0000, r(0,0,2,0), 1'b0, "rr_rel2"};
        vecs[10] = '{4'b1111, r(1,0,3,2), 4'b0000, 4'b1111, 4'b1111, r(1,0,3,2), 1'b0, "perm_all"};
        vecs[11] = '{4'b0000, r(0,0,0,0), 4'b1111, 4'b0000, 4'b0000, r(1,0,3,2), 1'b0, "perm_rel_all"};
        vecs[12] = '{4'b0000, r(0,0,0,0), 4'b0010, 4'b0000, 4'b0000, r(1,0,3,2), 1'b0, "stray_relieve"};
        vecs[13] = '{4'b0001, r(0,0,0,5), 4'b0000, 4'b0000, 4'b0000, r(1,0,3,2), 1'b1, "bad_index"};
        vecs[14] = '{4'b0000, r(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, r(1,0,3,2), 1'b1, "bad_sticky"};
        vecs[15] = '{4'b0010, r(0,0,0,0), 4'b0000, 4'b0010, 4'b0001, r(1,0,3,1), 1'b1, "in1_to_out0"};
        vecs[16] = '{4'b0010, r(0,0,2,0), 4'b0000, 4'b0010, 4'b0001, r(1,0,3,1), 1'b1, "holder_req_ignored"};
        vecs[17] = '{4'b0000, r(0,0,0,0), 4'b0010, 4'b0000, 4'b0000, r(1,0,3,1), 1'b1, "rel1_out0"};
        vecs[18] = '{4'b1001, r(0,0,0,0), 4'b0000, 4'b1000, 4'b0001, r(1,0,3,3), 1'b1, "rr_ptr2_picks3"};

        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].valid, vecs[i].req, vecs[i].relieve, vecs[i].status,
                 vecs[i].busy, vecs[i].sel, vecs[i].bad, vecs[i].name);
        end

        // Relieve and new request on the same output in one cycle
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(4'b0100, r(0,0,0,0), 4'b0000, 4'b0100, 4'b0001, r(0,0,0,2), 1'b0, "h_in2_out0");
        step(4'b1000, r(0,0,0,0), 4'b0100, 4'b0000, 4'b0000, r(0,0,0,2), 1'b0, "h_rel2_req3");
        step(4'b1000, r(0,0,0,0), 4'b0000, 4'b1000, 4'b0001, r(0,0,0,3), 1'b0, "h_grant3");
        step(4'b0011, r(0,0,2,1), 4'b0000, 4'b1011, 4'b0111, r(0,1,0,3), 1'b0, "h_three_held");

        // Asynchronous reset between clock edges drops everything
        @(negedge clk);
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        // ptr1 was 1 before reset; from pointer 0 input 0 must win
        step(4'b0011, r(0,0,1,1), 4'b0000, 4'b0001, 4'b0010, r(0,0,0,0), 1'b0, "post_reset_ptr0");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
